// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access-size encoding, FSM states
// and the request legality check used by the responder.
package dmem_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned, out-of-range, unknown-size and unsigned-store requests are
    // rejected; the word-index check covers the whole address so nothing aliases.
    function automatic logic req_error(
        input logic        we,
        input word_t       addr,
        input logic [2:0]  size,
        input int unsigned depth
    );
        logic err;
        err = 1'b0;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = addr[0];
            SZ_W:    err = |addr[1:0];
            SZ_BU:   err = we;
            SZ_HU:   err = we | addr[0];
            default: err = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into the addressed lanes of the old
// word and extracts/extends the addressed byte or half for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    input  word_t      wdata,
    input  word_t      old_word,
    output word_t      merged_word,
    output word_t      load_data
);

    logic [3:0] byte_en;
    word_t      lane_data;
    word_t      shifted;

    // Store data is right-aligned, so replicate it across lanes and let the
    // byte enables pick the addressed ones.
    always_comb begin
        byte_en   = 4'b0000;
        lane_data = '0;
        case (size)
            SZ_B: begin
                byte_en   = 4'b0001 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            SZ_H: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            SZ_W: begin
                byte_en   = 4'b1111;
                lane_data = wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                lane_data = '0;
            end
        endcase
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged_word[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        shifted   = old_word >> {addr_lo, 3'b000};
        load_data = '0;
        case (size)
            SZ_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            SZ_BU:   load_data = {24'd0, shifted[7:0]};
            SZ_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            SZ_HU:   load_data = {16'd0, shifted[15:0]};
            SZ_W:    load_data = old_word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: accepts one request at a time, commits the
// access on the edge entering RESP and holds the response until it is taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_e     state;
    logic [3:0] cnt;

    logic       cap_we;
    word_t      cap_addr;
    word_t      cap_wdata;
    logic [2:0] cap_size;

    logic       cur_we;
    word_t      cur_addr;
    word_t      cur_wdata;
    logic [2:0] cur_size;
    logic       cur_err;
    logic       commit;

    logic [IDX_W-1:0] idx;
    word_t            old_word;
    word_t            merged_word;
    word_t            load_data;

    word_t mem [DEPTH_WORDS];

    // With zero wait states the access commits on the accepting edge itself, so
    // the datapath sees the live request in IDLE and the captured one otherwise.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_size  = req_size;
        end else begin
            cur_we    = cap_we;
            cur_addr  = cap_addr;
            cur_wdata = cap_wdata;
            cur_size  = cap_size;
        end
    end

    assign cur_err  = req_error(cur_we, cur_addr, cur_size, DEPTH_WORDS);
    assign commit   = ((state == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd1));
    assign idx      = cur_addr[IDX_W+1:2];
    assign old_word = mem[idx];

    dmem_lane_align u_align (
        .size        (cur_size),
        .addr_lo     (cur_addr[1:0]),
        .wdata       (cur_wdata),
        .old_word    (old_word),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // Storage is never reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_we && !cur_err) begin
            mem[idx] <= merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_size  <= req_size;
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state      <= ST_RESP;
                            cnt        <= 4'd0;
                            resp_valid <= 1'b1;
                            resp_err   <= cur_err;
                            resp_rdata <= (cur_err || cur_we) ? '0 : load_data;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state      <= ST_RESP;
                        cnt        <= 4'd0;
                        resp_valid <= 1'b1;
                        resp_err   <= cur_err;
                        resp_rdata <= (cur_err || cur_we) ? '0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 Parameter WAIT_STATES, default 2: extra cycles inserted between request acceptance and response (range 0-15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data, already extended; 0 for stores and errors.
REQ-014 resp_err  output  1  request was rejected (no memory effect).

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0 and req_valid SHALL be ignored.
REQ-017 On an IDLE cycle with req_valid=1, the block SHALL capture we/addr/wdata/size, go to WAIT with counter=WAIT_STATES, or go directly to RESP if WAIT_STATES=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle; on the cycle it reaches 1 the FSM SHALL go to RESP.
REQ-019 resp_valid SHALL assert exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-020 The memory read or write SHALL take effect on the edge entering RESP, and only on that edge.
REQ-021 In RESP, resp_valid=1, and resp_rdata/resp_err SHALL stay stable until a cycle with resp_ready=1; the FSM SHALL then return to IDLE.
REQ-022 A new request SHALL be accepted no earlier than the cycle after the response handshake, giving a throughput of one transaction per WAIT_STATES+2 cycles minimum.
REQ-023 Error conditions SHALL be:
- H/HU with addr[0]=1;
- W with addr[1:0]!=00;
- word index addr[31:2] >= DEPTH_WORDS;
- size in {011, 110, 111};
- store with size BU or HU.
REQ-024 On error, the block SHALL perform no write, drive resp_rdata=0 and resp_err=1, with the same latency as a normal request.
REQ-025 Stores SHALL write only the addressed lanes:
- SB: the lane selected by addr[1:0] gets wdata[7:0];
- SH: the lanes selected by addr[1] get wdata[15:0];
- SW: all four lanes.
Other lanes SHALL be unchanged.
REQ-026 Loads SHALL extract the addressed byte or half and extend it:
- B/H: sign-extend;
- BU/HU: zero-extend;
- W: full word.
REQ-027 Store responses SHALL return resp_rdata=0 and resp_err=0.
REQ-028 Address bits above the word index SHALL be checked only through REQ-023; addresses SHALL never wrap or alias.

Reset
REQ-029 Reset SHALL force state=IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-030 Reset asserted in WAIT SHALL abort the transaction with no memory write.
REQ-031 Reset asserted in RESP SHALL drop resp_valid on the next edge; a write already committed stays.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-034 Shared package dmem_pkg SHALL hold:
- the size encoding enum (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
- the FSM state typedef;
- a 32-bit word typedef.
REQ-035 One combinational sub-module, dmem_lane_align, SHALL hold the byte-enable/merge logic and the load extract/extend logic; the FSM and storage SHALL live in dmem_responder.

Verification
REQ-036 SW 0xDEADBEEF @0x10, then LW @0x10 with WAIT_STATES=2 -> resp_valid 3 cycles after each accept; rdata=0xDEADBEEF, err=0.
REQ-037 Following REQ-036: SB 0x7F @0x13, then LB @0x13 -> 0x0000007F; LBU @0x11 -> 0x000000BE; LB @0x11 -> 0xFFFFFFBE; LHU @0x12 -> 0x00007FAD.
REQ-038 LW @0x12, SH @0x11, LB @0x400 (DEPTH_WORDS=256), size 011 -> err=1, rdata=0 each; subsequent LW @0x10 proves memory unchanged.
REQ-039 Hold resp_ready=0 for 5 cycles in RESP with req_valid=1 throughout -> outputs stable, req_ready=0, no second request accepted; accepted one cycle after the handshake.
REQ-040 Assert reset during WAIT of SW 0x12345678 @0x20 -> resp_valid never asserts; later LW @0x20 returns the prior contents.
REQ-041 WAIT_STATES=0 back-to-back loads with resp_ready=1 -> resp_valid one cycle after accept; accepts every 2 cycles.
